// File: rtl/seg7_pkg.sv
// Shared definitions for the four-digit multiplexed 7-segment display path.
// Holds the hex-to-segment table used by both the scan driver (encoder) and
// the scan decoder, so the two ends of the display path stay consistent.
//   SEG_TABLE   : active-high segment patterns, bit order a..g, a = bit 6
//   SEG_BLANK   : all segments off
//   scan_state_e: decoder FSM state encoding
//   AN*_IDX     : digit index of each anode (an3 is the leftmost digit)
package seg7_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Entry 15 first so that SEG_TABLE[v] is the pattern for hex value v.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h7B, 7'h7F,
    7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HELD   = 2'd2
  } scan_state_e;

  localparam logic [1:0] AN0_IDX = 2'd0;
  localparam logic [1:0] AN1_IDX = 2'd1;
  localparam logic [1:0] AN2_IDX = 2'd2;
  localparam logic [1:0] AN3_IDX = 2'd3;

  // Encoder-side helper: hex value to active-high segment pattern.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
    return SEG_TABLE[value];
  endfunction

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// Display bus between a multiplexed 7-segment source and the scan decoder.
//   an3..an0, a..g, dp : anode / segment pins as seen on the board
//   clr_err            : one-cycle pulse clearing the sticky error flags
//   digits, blank      : rebuilt characters and per-digit blank flags
//   frame_valid        : one-cycle strobe when digits/blank update
//   seg_err, multi_err, lost : sticky protocol-error flags
// master: the side that drives the pins (driver or bench)
// slave : the scan decoder
interface seg7_scan_decoder_if;
  logic        an3, an2, an1, an0;
  logic        a, b, c, d, e, f, g;
  logic        dp;
  logic        clr_err;
  logic [15:0] digits;
  logic [3:0]  blank;
  logic        frame_valid;
  logic        seg_err;
  logic        multi_err;
  logic        lost;

  modport master (
    output an3, an2, an1, an0, a, b, c, d, e, f, g, dp, clr_err,
    input  digits, blank, frame_valid, seg_err, multi_err, lost
  );

  modport slave (
    input  an3, an2, an1, an0, a, b, c, d, e, f, g, dp, clr_err,
    output digits, blank, frame_valid, seg_err, multi_err, lost
  );
endinterface

// File: rtl/seg7_to_hex.sv
// Combinational 7-segment pattern decoder.
//   seg_i      : active-high pattern, bit order a..g (a = bit 6)
//   value_o    : hex value of the matching table entry (0 when no match)
//   is_blank_o : pattern is all segments off
//   is_valid_o : pattern matches one of the 16 hex characters
module seg7_to_hex
  import seg7_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] value_o,
  output logic       is_blank_o,
  output logic       is_valid_o
);

  logic [15:0]      match;
  logic [15:0][3:0] term;

  // Table entries are unique, so at most one term is non-zero and an OR
  // reduction yields the matching index.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_match
      assign match[gi] = (seg_i == SEG_TABLE[gi]);
      assign term[gi]  = match[gi] ? 4'(gi) : 4'h0;
    end
  endgenerate

  always_comb begin
    value_o = 4'h0;
    for (int i = 0; i < 16; i++) begin
      value_o = value_o | term[i];
    end
  end

  assign is_valid_o = |match;
  assign is_blank_o = (seg_i == SEG_BLANK);

endmodule

// File: rtl/seg7_scan_decoder.sv
// Scan decoder: samples the anode/segment lines of a four-digit multiplexed
// 7-segment display and rebuilds the four hex characters.
//   clk, reset : system clock, asynchronous active-high reset
//   bus        : slave side of seg7_scan_decoder_if (pins in, results out)
// A digit is accepted once the same anode/segment sample has been seen
// SETTLE times in a row; a frame is published once all four digits have
// been accepted. Sticky flags report bad patterns, overlapping anodes and
// loss of scan activity for TIMEOUT cycles.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int ACTIVE_LOW = 1,
  parameter int SETTLE     = 4,
  parameter int TIMEOUT    = 65535
) (
  input  logic               clk,
  input  logic               reset,
  seg7_scan_decoder_if.slave bus
);

  localparam logic [11:0] PIN_POL = (ACTIVE_LOW != 0) ? 12'hFFF : 12'h000;
  localparam int          IDLE_W  = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX   = IDLE_W'(TIMEOUT);
  localparam logic [7:0]        SETTLE_CNT = 8'(SETTLE);

  // Input stage: one register on all 12 pins, normalised to 1 = asserted.
  logic [11:0] pins_q;
  logic [3:0]  an_s;
  logic [6:0]  seg_s;
  logic        dp_unused;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pins_q <= '0;
    end else begin
      pins_q <= {bus.an3, bus.an2, bus.an1, bus.an0,
                 bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g,
                 bus.dp} ^ PIN_POL;
    end
  end

  assign an_s      = pins_q[11:8];
  assign seg_s     = pins_q[7:1];
  assign dp_unused = pins_q[0];

  // Sample classification.
  logic       smp_gap, smp_multi, smp_valid;
  logic [1:0] smp_idx;

  always_comb begin
    smp_gap   = (an_s == 4'd0);
    // Clearing the lowest set bit leaves something only if 2+ bits are set.
    smp_multi = ((an_s & (an_s - 4'd1)) != 4'd0);
    smp_valid = !smp_gap && !smp_multi;
    case (an_s)
      4'b1000: smp_idx = AN3_IDX;
      4'b0100: smp_idx = AN2_IDX;
      4'b0010: smp_idx = AN1_IDX;
      default: smp_idx = AN0_IDX;
    endcase
  end

  // Dwell-tracking FSM.
  scan_state_e state_q;
  logic [1:0]  idx_q;
  logic [6:0]  pat_q;
  logic [7:0]  cnt_q;
  logic        same;
  logic        settle_hit;

  assign same       = smp_valid && (smp_idx == idx_q) && (seg_s == pat_q);
  assign settle_hit = (state_q == ST_SETTLE) && same &&
                      ((cnt_q + 8'd1) == SETTLE_CNT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      pat_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (smp_valid) begin
            idx_q   <= smp_idx;
            pat_q   <= seg_s;
            cnt_q   <= 8'd1;
            state_q <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (!smp_valid) begin
            state_q <= ST_IDLE;
          end else if (same) begin
            cnt_q <= cnt_q + 8'd1;
            if (settle_hit) begin
              state_q <= ST_HELD;
            end
          end else begin
            idx_q <= smp_idx;
            pat_q <= seg_s;
            cnt_q <= 8'd1;
          end
        end
        ST_HELD: begin
          // An identical sample is ignored so a digit is captured once per dwell.
          if (!smp_valid) begin
            state_q <= ST_IDLE;
          end else if (!same) begin
            idx_q   <= smp_idx;
            pat_q   <= seg_s;
            cnt_q   <= 8'd1;
            state_q <= ST_SETTLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Decode the current sample; on settle_hit it equals the latched pattern.
  logic [3:0] hex_val;
  logic       hex_blank, hex_valid;

  seg7_to_hex u_to_hex (
    .seg_i      (seg_s),
    .value_o    (hex_val),
    .is_blank_o (hex_blank),
    .is_valid_o (hex_valid)
  );

  logic accept, seg_bad;
  assign accept  = settle_hit && (hex_valid || hex_blank);
  assign seg_bad = settle_hit && !hex_valid && !hex_blank;

  // Staging, frame publication, timeout and sticky flags.
  logic [3:0][3:0]   stage_val_q, stage_val_d;
  logic [3:0]        stage_blank_q, stage_blank_d;
  logic [3:0]        mask_q, mask_d;
  logic [15:0]       digits_q, digits_d;
  logic [3:0]        blank_q, blank_d;
  logic              frame_valid_q, frame_valid_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic              seg_err_q, seg_err_d;
  logic              multi_err_q, multi_err_d;
  logic              lost_q, lost_d;
  logic              lost_evt;

  always_comb begin
    stage_val_d   = stage_val_q;
    stage_blank_d = stage_blank_q;
    mask_d        = mask_q;
    digits_d      = digits_q;
    blank_d       = blank_q;
    frame_valid_d = 1'b0;
    idle_cnt_d    = idle_cnt_q;
    lost_evt      = 1'b0;

    if (accept) begin
      if (hex_blank) begin
        stage_blank_d[idx_q] = 1'b1;
      end else begin
        stage_val_d[idx_q]   = hex_val;
        stage_blank_d[idx_q] = 1'b0;
      end
      mask_d[idx_q] = 1'b1;
      idle_cnt_d    = '0;
      // Publish using the staging values that include this capture.
      if (mask_d == 4'hF) begin
        digits_d      = stage_val_d;
        blank_d       = stage_blank_d;
        frame_valid_d = 1'b1;
        mask_d        = 4'h0;
      end
    end else if (idle_cnt_q != IDLE_MAX) begin
      // Saturating: the timeout action happens once per quiet period.
      idle_cnt_d = idle_cnt_q + IDLE_W'(1);
      if (idle_cnt_d == IDLE_MAX) begin
        lost_evt = 1'b1;
        mask_d   = 4'h0;
      end
    end

    // Set wins over a simultaneous clear.
    seg_err_d   = (seg_err_q   && !bus.clr_err) || seg_bad;
    multi_err_d = (multi_err_q && !bus.clr_err) || smp_multi;
    lost_d      = (lost_q      && !bus.clr_err) || lost_evt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_val_q   <= '0;
      stage_blank_q <= 4'hF;
      mask_q        <= '0;
      digits_q      <= 16'h0000;
      blank_q       <= 4'hF;
      frame_valid_q <= 1'b0;
      idle_cnt_q    <= '0;
      seg_err_q     <= 1'b0;
      multi_err_q   <= 1'b0;
      lost_q        <= 1'b0;
    end else begin
      stage_val_q   <= stage_val_d;
      stage_blank_q <= stage_blank_d;
      mask_q        <= mask_d;
      digits_q      <= digits_d;
      blank_q       <= blank_d;
      frame_valid_q <= frame_valid_d;
      idle_cnt_q    <= idle_cnt_d;
      seg_err_q     <= seg_err_d;
      multi_err_q   <= multi_err_d;
      lost_q        <= lost_d;
    end
  end

  assign bus.digits      = digits_q;
  assign bus.blank       = blank_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.seg_err     = seg_err_q;
  assign bus.multi_err   = multi_err_q;
  assign bus.lost        = lost_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder (ACTIVE_LOW=1, SETTLE=4,
// TIMEOUT=100). Expected frames go into a queue when a scan is driven and
// are popped and compared whenever the DUT strobes frame_valid.
module tb_seg7_scan_decoder;

  localparam int TB_AL = 1;

  logic clk;
  logic reset;

  seg7_scan_decoder_if bus ();

  seg7_scan_decoder #(
    .ACTIVE_LOW (TB_AL),
    .SETTLE     (4),
    .TIMEOUT    (100)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] vals;
    logic [3:0]  blk;
    logic        rev;
    logic [15:0] exp_digits;
    logic [3:0]  exp_blank;
  } vec_t;

  typedef struct {
    logic [15:0] digits;
    logic [3:0]  blank;
  } frame_t;

  vec_t   vt[6];
  frame_t exp_q[$];
  int     n_vec;
  int     n_miss;
  int     n_frames;

  function automatic logic [6:0] enc(input logic [3:0] v);
    case (v)
      4'h0: return 7'h7E;  4'h1: return 7'h30;  4'h2: return 7'h6D;  4'h3: return 7'h79;
      4'h4: return 7'h33;  4'h5: return 7'h5B;  4'h6: return 7'h5F;  4'h7: return 7'h70;
      4'h8: return 7'h7F;  4'h9: return 7'h7B;  4'hA: return 7'h77;  4'hB: return 7'h1F;
      4'hC: return 7'h4E;  4'hD: return 7'h3D;  4'hE: return 7'h4F;  default: return 7'h47;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Advance n clock edges, sampling 1 time unit after each edge and
  // scoreboarding any frame strobe.
  task automatic tick(input int n);
    frame_t fr;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (bus.frame_valid === 1'b1) begin
        n_frames++;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_frame: got digits %04h blank %0h, expected no frame",
                   bus.digits, bus.blank);
        end else begin
          fr = exp_q.pop_front();
          chk("frame_digits", 32'(bus.digits), 32'(fr.digits));
          chk("frame_blank", 32'(bus.blank), 32'(fr.blank));
        end
      end
    end
  endtask

  task automatic set_pins(input logic [3:0] an, input logic [6:0] seg);
    logic [3:0] pa;
    logic [6:0] ps;
    pa = (TB_AL != 0) ? ~an : an;
    ps = (TB_AL != 0) ? ~seg : seg;
    {bus.an3, bus.an2, bus.an1, bus.an0} = pa;
    {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g} = ps;
    bus.dp = 1'($urandom_range(0, 1));
  endtask

  task automatic show(input int idx, input logic [6:0] seg, input int n);
    set_pins(4'(1 << idx), seg);
    tick(n);
  endtask

  task automatic gap(input int n);
    set_pins(4'h0, 7'h00);
    tick(n);
  endtask

  task automatic clr_pulse();
    bus.clr_err = 1'b1;
    tick(1);
    bus.clr_err = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    int w;
    n_vec    = 0;
    n_miss   = 0;
    n_frames = 0;

    //                vals      blk     rev   digits    blank
    vt[0] = '{16'h3210, 4'b0000, 1'b0, 16'h3210, 4'b0000};
    vt[1] = '{16'hABCD, 4'b0000, 1'b0, 16'hABCD, 4'b0000};
    vt[2] = '{16'hEF89, 4'b0000, 1'b0, 16'hEF89, 4'b0000};
    vt[3] = '{16'h5674, 4'b1000, 1'b0, 16'hE674, 4'b1000};
    vt[4] = '{16'h0000, 4'b0101, 1'b1, 16'h0604, 4'b0101};
    vt[5] = '{16'hF1E2, 4'b0000, 1'b0, 16'hF1E2, 4'b0000};

    reset       = 1'b1;
    bus.clr_err = 1'b0;
    set_pins(4'h0, 7'h00);
    tick(3);
    chk("rst_digits", 32'(bus.digits), 32'h0000);
    chk("rst_blank", 32'(bus.blank), 32'hF);
    chk("rst_frame_valid", 32'(bus.frame_valid), 32'h0);
    chk("rst_seg_err", 32'(bus.seg_err), 32'h0);
    chk("rst_multi_err", 32'(bus.multi_err), 32'h0);
    chk("rst_lost", 32'(bus.lost), 32'h0);
    reset = 1'b0;
    tick(2);

    // Table-driven full scans.
    for (int v = 0; v < 6; v++) begin
      exp_q.push_back('{vt[v].exp_digits, vt[v].exp_blank});
      for (int k = 0; k < 4; k++) begin
        int         idx;
        logic [3:0] nib;
        idx = (vt[v].rev != 0) ? k : 3 - k;
        nib = vt[v].vals[idx*4 +: 4];
        show(idx, (vt[v].blk[idx] != 0) ? 7'h00 : enc(nib), 6);
      end
      gap(2);
      chk("scan_frame_seen", 32'(exp_q.size()), 32'h0);
      chk("scan_errs", {29'h0, bus.seg_err, bus.multi_err, bus.lost}, 32'h0);
    end

    // Short dwell is not captured; exact capture latency on a full dwell.
    f0 = n_frames;
    show(1, 7'h6D, 3);
    gap(2);
    show(3, enc(4'h5), 6);
    show(2, enc(4'hA), 6);
    show(0, enc(4'hC), 6);
    gap(2);
    chk("short_dwell_no_frame", 32'(n_frames), 32'(f0));
    exp_q.push_back('{16'h5A2C, 4'b0000});
    set_pins(4'b0010, 7'h6D);
    tick(4);
    set_pins(4'h0, 7'h00);
    chk("latency_edge4", 32'(bus.frame_valid), 32'h0);
    tick(1);
    chk("latency_edge5", 32'(bus.frame_valid), 32'h1);
    tick(1);
    chk("strobe_one_cycle", 32'(bus.frame_valid), 32'h0);
    chk("latency_frame_seen", 32'(exp_q.size()), 32'h0);

    // Two anodes at once.
    f0 = n_frames;
    set_pins(4'b0101, enc(4'h7));
    tick(1);
    set_pins(4'h0, 7'h00);
    tick(1);
    chk("multi_err_set", 32'(bus.multi_err), 32'h1);
    clr_pulse();
    chk("multi_err_clr", 32'(bus.multi_err), 32'h0);
    chk("multi_no_frame", 32'(n_frames), 32'(f0));

    // Undecodable pattern, then a blank digit completing a frame.
    show(3, 7'h01, 10);
    gap(2);
    chk("seg_err_set", 32'(bus.seg_err), 32'h1);
    f0 = n_frames;
    show(2, enc(4'h3), 6);
    show(1, enc(4'h4), 6);
    show(0, enc(4'h5), 6);
    gap(2);
    chk("seg_err_mask_unchanged", 32'(n_frames), 32'(f0));
    exp_q.push_back('{16'h5345, 4'b1000});
    show(3, 7'h00, 6);
    gap(2);
    chk("blank_frame_seen", 32'(exp_q.size()), 32'h0);
    clr_pulse();
    chk("seg_err_clr", 32'(bus.seg_err), 32'h0);

    // Timeout after three digits.
    show(3, enc(4'h7), 6);
    show(2, enc(4'h8), 6);
    show(1, enc(4'h9), 6);
    gap(1);
    tick(85);
    chk("lost_not_yet", 32'(bus.lost), 32'h0);
    w = 0;
    while (bus.lost !== 1'b1 && w < 30) begin
      tick(1);
      w++;
    end
    chk("lost_set", 32'(bus.lost), 32'h1);
    f0 = n_frames;
    show(0, enc(4'h1), 6);
    gap(2);
    chk("timeout_mask_cleared", 32'(n_frames), 32'(f0));
    exp_q.push_back('{16'h7891, 4'b0000});
    show(3, enc(4'h7), 6);
    show(2, enc(4'h8), 6);
    show(1, enc(4'h9), 6);
    gap(2);
    chk("after_lost_frame_seen", 32'(exp_q.size()), 32'h0);
    chk("lost_sticky", 32'(bus.lost), 32'h1);
    clr_pulse();
    chk("lost_clr", 32'(bus.lost), 32'h0);

    // Reset in the middle of a dwell with three digits masked.
    set_pins(4'b1100, enc(4'h1));
    tick(1);
    gap(2);
    chk("pre_reset_multi", 32'(bus.multi_err), 32'h1);
    show(3, enc(4'h1), 6);
    show(2, enc(4'h2), 6);
    show(1, enc(4'h3), 6);
    set_pins(4'b0001, enc(4'h4));
    tick(2);
    reset = 1'b1;
    #1;
    chk("arst_digits", 32'(bus.digits), 32'h0000);
    chk("arst_blank", 32'(bus.blank), 32'hF);
    chk("arst_frame_valid", 32'(bus.frame_valid), 32'h0);
    chk("arst_errs", {29'h0, bus.seg_err, bus.multi_err, bus.lost}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    tick(1);
    f0 = n_frames;
    show(0, enc(4'h4), 6);
    gap(2);
    chk("reset_mask_cleared", 32'(n_frames), 32'(f0));
    exp_q.push_back('{16'h1234, 4'b0000});
    show(3, enc(4'h1), 6);
    show(2, enc(4'h2), 6);
    show(1, enc(4'h3), 6);
    gap(2);
    chk("post_reset_frame_seen", 32'(exp_q.size()), 32'h0);
    chk("post_reset_errs", {29'h0, bus.seg_err, bus.multi_err, bus.lost}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
